// File: rtl/noise_gate.sv
// Noise gate: peak envelope follower, five-state gate FSM with hold timer, linear gain ramp.
// One-cycle sample latency; no backpressure, a sample is consumed on every clk_48 edge.
module noise_gate #(
  parameter int HOLD         = 2400,
  parameter int ATTACK_STEP  = 64,
  parameter int RELEASE_STEP = 8,
  parameter int ENV_SHIFT    = 6
) (
  input  logic        clk_48,
  input  logic        reset,
  input  logic        enable,
  input  logic [14:0] threshold,
  input  logic [15:0] gateIn,
  output logic [15:0] gateOut,
  output logic        gate_open
);

  localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_INIT = HW'(HOLD - 1);
  localparam logic [15:0]     UNITY     = 16'h8000;
  localparam logic [16:0]     ATT_INC   = 17'(ATTACK_STEP);
  localparam logic [16:0]     REL_DEC   = 17'(RELEASE_STEP);

  typedef enum logic [2:0] {
    S_CLOSED  = 3'd0,
    S_ATTACK  = 3'd1,
    S_OPEN    = 3'd2,
    S_HOLD    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [14:0]        r_env;
  logic [15:0]        r_gain;
  logic [HW-1:0]      r_hold_cnt;
  logic [15:0]        r_out;
  logic               r_gate_open;

  logic [14:0]        w_abs;
  logic [14:0]        w_env_nxt;
  logic [14:0]        w_thr_close;
  logic               w_env_ge_open;
  logic               w_env_lt_close;
  logic [16:0]        w_gain_up;
  logic [15:0]        w_gain_att;
  logic [15:0]        w_gain_rel;
  logic [15:0]        w_gain_nxt;
  logic [HW-1:0]      w_hold_nxt;
  logic               w_gate_open_nxt;
  logic signed [32:0] w_prod;
  logic signed [32:0] w_shift;
  logic [15:0]        w_out_sat;

  // -32768 has no positive 16-bit counterpart, so it clips to 32767.
  always_comb begin
    w_abs = gateIn[14:0];
    if (gateIn[15]) begin
      if (gateIn[14:0] == 15'd0) begin
        w_abs = 15'h7fff;
      end else begin
        w_abs = ~gateIn[14:0] + 15'd1;
      end
    end
  end

  assign w_env_nxt      = (w_abs > r_env) ? w_abs : (r_env - (r_env >> ENV_SHIFT));
  assign w_thr_close    = threshold >> 1;
  assign w_env_ge_open  = (r_env >= threshold);
  assign w_env_lt_close = (r_env < w_thr_close);

  assign w_gain_up  = {1'b0, r_gain} + ATT_INC;
  assign w_gain_att = (w_gain_up >= {1'b0, UNITY}) ? UNITY : w_gain_up[15:0];
  assign w_gain_rel = ({1'b0, r_gain} > REL_DEC) ? (r_gain - REL_DEC[15:0]) : 16'd0;

  always_ff @(posedge clk_48) begin
    if (reset) begin
      r_state <= S_CLOSED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Level decisions use the registered envelope, so the FSM lags the peak by one edge.
  always_comb begin
    w_state_nxt = r_state;
    w_gain_nxt  = r_gain;
    w_hold_nxt  = r_hold_cnt;
    if (!enable) begin
      w_state_nxt = S_OPEN;
      w_gain_nxt  = UNITY;
      w_hold_nxt  = '0;
    end else begin
      case (r_state)
        S_CLOSED: begin
          if (w_env_ge_open) w_state_nxt = S_ATTACK;
        end
        S_ATTACK: begin
          if (w_env_lt_close) begin
            w_state_nxt = S_RELEASE;
          end else begin
            w_gain_nxt = w_gain_att;
            if (w_gain_att == UNITY) w_state_nxt = S_OPEN;
          end
        end
        S_OPEN: begin
          if (w_env_lt_close) begin
            w_state_nxt = S_HOLD;
            w_hold_nxt  = HOLD_INIT;
          end
        end
        S_HOLD: begin
          if (w_env_ge_open) begin
            w_state_nxt = S_OPEN;
          end else if (r_hold_cnt == '0) begin
            w_state_nxt = S_RELEASE;
          end else begin
            w_hold_nxt = r_hold_cnt - 1'b1;
          end
        end
        S_RELEASE: begin
          if (w_env_ge_open) begin
            w_state_nxt = S_ATTACK;
          end else begin
            w_gain_nxt = w_gain_rel;
            if (w_gain_rel == 16'd0) w_state_nxt = S_CLOSED;
          end
        end
        default: begin
          w_state_nxt = S_CLOSED;
          w_gain_nxt  = 16'd0;
          w_hold_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_gate_open_nxt = (w_state_nxt != S_CLOSED);
  end

  assign w_prod  = $signed(gateIn) * $signed({1'b0, r_gain});
  assign w_shift = w_prod >>> 15;

  always_comb begin
    if (w_shift > 33'sd32767) begin
      w_out_sat = 16'h7fff;
    end else if (w_shift < -33'sd32768) begin
      w_out_sat = 16'h8000;
    end else begin
      w_out_sat = w_shift[15:0];
    end
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      r_env       <= 15'd0;
      r_gain      <= 16'd0;
      r_hold_cnt  <= '0;
      r_out       <= 16'd0;
      r_gate_open <= 1'b0;
    end else begin
      r_env       <= w_env_nxt;
      r_gain      <= w_gain_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_out       <= w_out_sat;
      r_gate_open <= w_gate_open_nxt;
    end
  end

  assign gateOut   = r_out;
  assign gate_open = r_gate_open;

endmodule

// File: tb/tb_noise_gate.sv
// Directed bench for noise_gate at default parameters; a small envelope model locates the decay crossing.
module tb_noise_gate;

  logic        clk_48 = 1'b0;
  logic        reset;
  logic        enable;
  logic [14:0] threshold;
  logic signed [15:0] gateIn;
  logic signed [15:0] gateOut;
  logic        gate_open;

  int checks   = 0;
  int failures = 0;
  int m_env    = 0;
  int steps;

  always #5 clk_48 = ~clk_48;

  noise_gate dut (
    .clk_48    (clk_48),
    .reset     (reset),
    .enable    (enable),
    .threshold (threshold),
    .gateIn    (gateIn),
    .gateOut   (gateOut),
    .gate_open (gate_open)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance n edges; the envelope model follows the sample present at each edge.
  task automatic tick(input int n);
    int a;
    repeat (n) begin
      @(posedge clk_48);
      a = int'(gateIn);
      if (a < 0) a = (a == -32768) ? 32767 : -a;
      if (reset) m_env = 0;
      else if (a > m_env) m_env = a;
      else m_env = m_env - (m_env >> 6);
      #1;
    end
  endtask

  task automatic decay_to_close();
    steps = 0;
    while (m_env >= 500 && steps < 2000) begin
      tick(1);
      steps++;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; threshold = 15'd1000; gateIn = 16'sd12000;

    // Reset holds everything quiet even with a loud input
    tick(3);
    chk("rst_out", int'(gateOut), 0);
    chk("rst_open", int'(gate_open), 0);
    reset = 1'b0;
    tick(1);
    chk("rst_rel_e1_open", int'(gate_open), 0);
    tick(1);
    chk("rst_rel_e2_open", int'(gate_open), 1);

    // Attack ramp with constant 2000
    reset = 1'b1; gateIn = 16'sd2000;
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("att_e1_out", int'(gateOut), 0);
    tick(1);
    chk("att_e2_open", int'(gate_open), 1);
    tick(2);
    chk("att_e4_out", int'(gateOut), 3);
    tick(254);
    chk("att_e258_out", int'(gateOut), 996);
    tick(256);
    chk("att_e514_out", int'(gateOut), 1996);
    tick(1);
    chk("att_open_out", int'(gateOut), 2000);

    // Hold then release; 256 keeps the level below the close threshold and exposes gain>>7
    gateIn = 16'sd256;
    decay_to_close();
    tick(2400);
    chk("hold_end_open", int'(gate_open), 1);
    chk("hold_end_out", int'(gateOut), 256);
    tick(1);
    chk("rel_entry_out", int'(gateOut), 256);
    tick(1);
    chk("rel_n1_out", int'(gateOut), 256);
    tick(1);
    chk("rel_n2_out", int'(gateOut), 255);
    tick(2047);
    chk("rel_n2049_out", int'(gateOut), 128);
    tick(1952);
    chk("rel_n4001_out", int'(gateOut), 6);
    tick(94);
    chk("rel_n4095_open", int'(gate_open), 1);
    tick(1);
    chk("closed_open", int'(gate_open), 0);
    chk("closed_out", int'(gateOut), 0);
    tick(5);
    chk("closed_stay", int'(gate_open), 0);

    // Re-open, decay, and re-trigger mid-release at gain 16384
    gateIn = 16'sd2000;
    tick(514);
    chk("reopen_open", int'(gate_open), 1);
    tick(1);
    chk("reopen_out", int'(gateOut), 2000);
    gateIn = 16'sd256;
    decay_to_close();
    tick(2401);
    tick(2047);
    gateIn = 16'sd5000;
    tick(1);
    chk("retrig_x1_out", int'(gateOut), 2501);
    tick(1);
    chk("retrig_x2_out", int'(gateOut), 2500);
    chk("retrig_x2_open", int'(gate_open), 1);
    tick(1);
    chk("retrig_x3_out", int'(gateOut), 2500);
    tick(1);
    chk("retrig_x4_out", int'(gateOut), 2509);
    tick(254);
    chk("retrig_x258_out", int'(gateOut), 4990);
    tick(1);
    chk("retrig_full_out", int'(gateOut), 5000);

    // Bypass forces unity from a closed gate; full-scale samples pass unchanged
    reset = 1'b1;
    tick(1);
    reset = 1'b0; enable = 1'b0; threshold = 15'd30000; gateIn = 16'sd0;
    tick(1);
    chk("byp_force_open", int'(gate_open), 1);
    chk("byp_first_out", int'(gateOut), 0);
    gateIn = -16'sd32768;
    tick(1);
    chk("byp_neg_full", int'(gateOut), -32768);
    gateIn = 16'sd32767;
    tick(1);
    chk("byp_pos_full", int'(gateOut), 32767);
    gateIn = 16'sd0;
    tick(40);
    chk("byp_quiet_open", int'(gate_open), 1);
    gateIn = -16'sd1000;
    tick(1);
    chk("byp_neg_out", int'(gateOut), -1000);

    // Reset mid-attack with a negative input (floor on the arithmetic shift)
    enable = 1'b1; threshold = 15'd1000; reset = 1'b1; gateIn = -16'sd2000;
    tick(1);
    reset = 1'b0;
    tick(127);
    chk("midramp_out", int'(gateOut), -485);
    chk("midramp_open", int'(gate_open), 1);
    reset = 1'b1;
    tick(1);
    chk("midrst_out", int'(gateOut), 0);
    chk("midrst_open", int'(gate_open), 0);
    reset = 1'b0;
    tick(1);
    chk("midrst_env_open", int'(gate_open), 0);
    chk("midrst_env_out", int'(gateOut), 0);
    tick(1);
    chk("midrst_reattack", int'(gate_open), 1);

    // Zero threshold opens on silence and never closes
    reset = 1'b1; threshold = 15'd0; gateIn = 16'sd0;
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("thr0_open", int'(gate_open), 1);
    tick(600);
    chk("thr0_stay", int'(gate_open), 1);
    gateIn = 16'sd1000;
    tick(1);
    chk("thr0_unity_out", int'(gateOut), 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
